// File: rtl/fa_n_bit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fa_n_bit_pkg
// Description : Shared datapath constants and helpers for the ripple adder.
// Revision    : 1.0 - initial release
// ============================================================================
package fa_n_bit_pkg;

    localparam int DATA_WIDTH = 32;

    // Signed overflow is the disagreement between carry into and out of the MSB.
    function automatic logic overflow_flag(input logic carry_into_msb,
                                           input logic carry_out_msb);
        return carry_into_msb ^ carry_out_msb;
    endfunction

endpackage : fa_n_bit_pkg
`default_nettype wire

// File: rtl/fa_n_bit_if.sv
`default_nettype none
// ============================================================================
// Module      : fa_n_bit_if
// Description : Operand/result bundle for the WIDTH-bit adder (bit 0 = MSB).
// Revision    : 1.0 - initial release
// ============================================================================
interface fa_n_bit_if
    import fa_n_bit_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
);
    logic [0:WIDTH-1] A;
    logic [0:WIDTH-1] B;
    logic             cin;
    logic [0:WIDTH-1] Sum;
    logic             cout;
    logic             of;

    modport master (
        output A, B, cin,
        input  Sum, cout, of
    );

    modport slave (
        input  A, B, cin,
        output Sum, cout, of
    );
endinterface : fa_n_bit_if
`default_nettype wire

// File: rtl/fa_n_bit_full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : Single-bit full adder cell used to build the ripple chain.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule : full_adder
`default_nettype wire

// File: rtl/fa_n_bit.sv
`default_nettype none
// ============================================================================
// Module      : fa_n_bit
// Description : WIDTH-bit ripple-carry adder with registered sum/carry/overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module fa_n_bit
    import fa_n_bit_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  wire logic   clk,
    input  wire logic   reset,
    fa_n_bit_if.slave   bus
);
    // Carry index follows the operand bit ordering: w_carry[WIDTH] enters the LSB.
    logic [0:WIDTH]   w_carry;
    logic [0:WIDTH-1] w_sum;
    logic             w_ovf;

    logic [0:WIDTH-1] r_sum;
    logic             r_cout;
    logic             r_of;

    assign w_carry[WIDTH] = bus.cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        full_adder u_fa (
            .a  (bus.A[i]),
            .b  (bus.B[i]),
            .ci (w_carry[i+1]),
            .s  (w_sum[i]),
            .co (w_carry[i])
        );
    end

    assign w_ovf = overflow_flag(w_carry[1], w_carry[0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_of   <= 1'b0;
        end else begin
            r_sum  <= w_sum;
            r_cout <= w_carry[0];
            r_of   <= w_ovf;
        end
    end

    assign bus.Sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.of   = r_of;

endmodule : fa_n_bit
`default_nettype wire

// File: tb/tb_fa_n_bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fa_n_bit
// Description : Directed and random checks of fa_n_bit against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fa_n_bit;
    localparam int WIDTH = 32;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    fa_n_bit_if #(.WIDTH(WIDTH)) bus ();

    fa_n_bit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic void ref_add(input  logic [31:0] a,
                                    input  logic [31:0] b,
                                    input  logic        ci,
                                    output logic [31:0] s,
                                    output logic        co,
                                    output logic        ov);
        logic [32:0] u;
        longint      sv;
        u  = {1'b0, a} + {1'b0, b} + {32'd0, ci};
        s  = u[31:0];
        co = u[32];
        sv = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
        ov = (sv > 64'sh7FFFFFFF) || (sv < -64'sh80000000);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [31:0] es,
                                 input logic ec, input logic eo);
        check_val({tag, ".sum"},  bus.Sum,                es);
        check_val({tag, ".cout"}, {31'd0, bus.cout},      {31'd0, ec});
        check_val({tag, ".of"},   {31'd0, bus.of},        {31'd0, eo});
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic ci);
        bus.A   = a;
        bus.B   = b;
        bus.cin = ci;
    endtask

    task automatic apply_check(input string tag, input logic [31:0] a,
                               input logic [31:0] b, input logic ci);
        logic [31:0] es;
        logic        ec, eo;
        drive(a, b, ci);
        @(posedge clk);
        #1;
        ref_add(a, b, ci, es, ec, eo);
        check_outputs(tag, es, ec, eo);
    endtask

    initial begin
        drive(32'd0, 32'd0, 1'b0);
        #1 reset = 1'b1;
        drive($urandom, $urandom, 1'b1);
        #2 check_outputs("rst_async", 32'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 check_outputs("rst_held", 32'd0, 1'b0, 1'b0);

        drive(32'd0, 32'd0, 1'b0);
        reset = 1'b0;
        apply_check("zero",        32'h0000_0000, 32'h0000_0000, 1'b0);
        apply_check("f000x2",      32'h0000_F000, 32'h0000_F000, 1'b0);
        apply_check("f000_plus0",  32'h0000_F000, 32'h0000_0000, 1'b0);
        apply_check("all1_nc",     32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        apply_check("all1_cin",    32'hFFFF_FFFD, 32'h0000_0001, 1'b1);
        apply_check("wrap_b1",     32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        apply_check("wrap_cin",    32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        apply_check("wrap_b1cin",  32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
        apply_check("ovf_pos",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        apply_check("ovf_neg",     32'h8000_0000, 32'h8000_0000, 1'b0);

        // Mid-cycle reset pulse must clear the held FFFFFFFF result before the next edge.
        apply_check("pre_pulse",   32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        #3 reset = 1'b1;
        #1 check_outputs("pulse_clear", 32'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1 check_outputs("pulse_hold", 32'd0, 1'b0, 1'b0);
        #2 reset = 1'b0;
        apply_check("post_pulse",  32'h1234_5678, 32'h0000_1111, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            apply_check("random", $urandom, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule : tb_fa_n_bit
`default_nettype wire
